// File: rtl/jt51_reg_file_pkg.sv
// ============================================================================
// jt51_reg_file_pkg : shared widths, encodings and modulation decode
// Rev 1.0
// ============================================================================
`default_nettype none

package jt51_reg_file_pkg;

    localparam int SLOT_W  = 5;
    localparam int N_SLOTS = 32;
    localparam int N_CH    = 8;

    typedef enum logic [1:0] {
        OP_M1 = 2'd0,
        OP_M2 = 2'd1,
        OP_C1 = 2'd2,
        OP_C2 = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        CON_0 = 3'd0, CON_1 = 3'd1, CON_2 = 3'd2, CON_3 = 3'd3,
        CON_4 = 3'd4, CON_5 = 3'd5, CON_6 = 3'd6, CON_7 = 3'd7
    } con_e;

    typedef enum logic [7:0] {
        REG_RL_FB_CON = 8'h20,
        REG_KC        = 8'h28,
        REG_KF        = 8'h30,
        REG_PMS_AMS   = 8'h38,
        REG_DT1_MUL   = 8'h40,
        REG_TL        = 8'h60,
        REG_KS_AR     = 8'h80,
        REG_AMS_D1R   = 8'hA0,
        REG_DT2_D2R   = 8'hC0,
        REG_D1L_RR    = 8'hE0
    } reg_base_e;

    typedef struct packed {
        logic prevprev1;
        logic internal_x;
        logic internal_y;
        logic prev2;
        logic prev1;
    } mod_sel_t;

    // Which earlier operator output feeds the current operator for a given algorithm
    function automatic mod_sel_t mod_decode(input logic [1:0] cur_op, input logic [2:0] con);
        mod_sel_t m;
        m = '0;
        case (cur_op)
            OP_M1: m.prevprev1 = 1'b1;
            OP_M2: begin
                m.prev2 = (con <= CON_2);
                m.prev1 = (con == CON_1) || (con == CON_5);
            end
            OP_C1: m.prev2 = (con == CON_0) || (con == CON_3) || (con == CON_4) ||
                             (con == CON_5) || (con == CON_6);
            default: begin
                m.prev2      = (con <= CON_4);
                m.prev1      = (con == CON_3);
                m.internal_x = (con == CON_2) || (con == CON_5);
            end
        endcase
        m.internal_y = (cur_op != OP_M1) && !(m.prev2 || m.prev1 || m.internal_x);
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jt51_reg_kon.sv
// ============================================================================
// jt51_reg_kon : per-slot key-on flags and CSM (all-key-on) round latch
// Rev 1.0
// ============================================================================
`default_nettype none

module jt51_reg_kon
    import jt51_reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cen_i,
    input  logic              up_keyon_i,
    input  logic [6:0]        din_i,
    input  logic              csm_i,
    input  logic              overflow_a_i,
    input  logic [SLOT_W-1:0] cycles_i,
    output logic              keyon_ii_o
);

    logic [N_SLOTS-1:0] kon_q;
    logic               csm_req_q;
    logic               csm_req_d;
    logic               csm_round_q;
    logic               w_wrap;
    logic [SLOT_W-1:0]  w_slot_ii;

    assign w_wrap    = (cycles_i == 5'd31);
    assign w_slot_ii = cycles_i - 5'd1;
    // A pending request is consumed at the wrap into slot 0
    assign csm_req_d = (csm_req_q & ~w_wrap) | (csm_i & overflow_a_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            kon_q       <= '0;
            csm_req_q   <= 1'b0;
            csm_round_q <= 1'b0;
        end else if (cen_i) begin
            if (up_keyon_i) begin
                kon_q[{OP_M1, din_i[2:0]}] <= din_i[3];
                kon_q[{OP_C1, din_i[2:0]}] <= din_i[4];
                kon_q[{OP_M2, din_i[2:0]}] <= din_i[5];
                kon_q[{OP_C2, din_i[2:0]}] <= din_i[6];
            end
            csm_req_q <= csm_req_d;
            if (w_wrap) begin
                csm_round_q <= csm_req_q;
            end
        end
    end

    assign keyon_ii_o = kon_q[w_slot_ii] | csm_round_q;

endmodule

`default_nettype wire

// File: rtl/jt51_reg_file.sv
// ============================================================================
// jt51_reg_file : YM2151 operator/channel parameter store and slot sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module jt51_reg_file
    import jt51_reg_file_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       up_dt1,
    input  logic       up_tl,
    input  logic       up_ks,
    input  logic       up_amsen,
    input  logic       up_dt2,
    input  logic       up_d1l,
    input  logic [1:0] op,
    input  logic [2:0] ch,
    input  logic [7:0] op_din,
    input  logic       up_rl,
    input  logic       up_kc,
    input  logic       up_kf,
    input  logic       up_pms,
    input  logic [2:0] ch_sel,
    input  logic [7:0] ch_din,
    input  logic       up_keyon,
    input  logic       csm,
    input  logic       overflow_A,
    output logic [1:0] rl_I,
    output logic [2:0] fb_II,
    output logic [2:0] con_I,
    output logic [6:0] kc_I,
    output logic [5:0] kf_I,
    output logic [2:0] pms_I,
    output logic [1:0] ams_VII,
    output logic [2:0] dt1_II,
    output logic [3:0] mul_VI,
    output logic [6:0] tl_VII,
    output logic [1:0] ks_III,
    output logic [4:0] arate_II,
    output logic       amsen_VII,
    output logic [4:0] rate1_II,
    output logic [1:0] dt2_I,
    output logic [4:0] rate2_II,
    output logic [3:0] d1l_I,
    output logic [3:0] rrate_II,
    output logic       keyon_II,
    output logic [1:0] cur_op,
    output logic       op31_no,
    output logic       op31_acc,
    output logic       zero,
    output logic       half,
    output logic [4:0] cycles,
    output logic       m1_enters,
    output logic       m2_enters,
    output logic       c1_enters,
    output logic       c2_enters,
    output logic       use_prevprev1,
    output logic       use_internal_x,
    output logic       use_internal_y,
    output logic       use_prev2,
    output logic       use_prev1
);

    logic [SLOT_W-1:0] cycles_q, cycles_d;

    logic [2:0] dt1_q   [N_SLOTS];
    logic [3:0] mul_q   [N_SLOTS];
    logic [6:0] tl_q    [N_SLOTS];
    logic [1:0] ks_q    [N_SLOTS];
    logic [4:0] ar_q    [N_SLOTS];
    logic       amsen_q [N_SLOTS];
    logic [4:0] d1r_q   [N_SLOTS];
    logic [1:0] dt2_q   [N_SLOTS];
    logic [4:0] d2r_q   [N_SLOTS];
    logic [3:0] d1l_q   [N_SLOTS];
    logic [3:0] rr_q    [N_SLOTS];

    logic [1:0] rl_q  [N_CH];
    logic [2:0] fb_q  [N_CH];
    logic [2:0] con_q [N_CH];
    logic [6:0] kc_q  [N_CH];
    logic [5:0] kf_q  [N_CH];
    logic [2:0] pms_q [N_CH];
    logic [1:0] ams_q [N_CH];

    logic [SLOT_W-1:0] w_wslot;
    logic [SLOT_W-1:0] w_s2, w_s3, w_s6, w_s7;
    mod_sel_t          w_mod;

    assign cycles_d = cycles_q + 5'd1;
    assign w_wslot  = {op, ch};

    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_q <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                dt1_q[i]   <= '0;
                mul_q[i]   <= '0;
                tl_q[i]    <= '0;
                ks_q[i]    <= '0;
                ar_q[i]    <= '0;
                amsen_q[i] <= 1'b0;
                d1r_q[i]   <= '0;
                dt2_q[i]   <= '0;
                d2r_q[i]   <= '0;
                d1l_q[i]   <= '0;
                rr_q[i]    <= '0;
            end
            for (int j = 0; j < N_CH; j++) begin
                rl_q[j]  <= '0;
                fb_q[j]  <= '0;
                con_q[j] <= '0;
                kc_q[j]  <= '0;
                kf_q[j]  <= '0;
                pms_q[j] <= '0;
                ams_q[j] <= '0;
            end
        end else if (cen) begin
            cycles_q <= cycles_d;
            // Strobes are levels: re-writing the same slot every cen is harmless
            if (up_dt1) begin
                dt1_q[w_wslot] <= op_din[6:4];
                mul_q[w_wslot] <= op_din[3:0];
            end
            if (up_tl)    tl_q[w_wslot] <= op_din[6:0];
            if (up_ks) begin
                ks_q[w_wslot] <= op_din[7:6];
                ar_q[w_wslot] <= op_din[4:0];
            end
            if (up_amsen) begin
                amsen_q[w_wslot] <= op_din[7];
                d1r_q[w_wslot]   <= op_din[4:0];
            end
            if (up_dt2) begin
                dt2_q[w_wslot] <= op_din[7:6];
                d2r_q[w_wslot] <= op_din[4:0];
            end
            if (up_d1l) begin
                d1l_q[w_wslot] <= op_din[7:4];
                rr_q[w_wslot]  <= op_din[3:0];
            end
            if (up_rl) begin
                rl_q[ch_sel]  <= ch_din[7:6];
                fb_q[ch_sel]  <= ch_din[5:3];
                con_q[ch_sel] <= ch_din[2:0];
            end
            if (up_kc)    kc_q[ch_sel] <= ch_din[6:0];
            if (up_kf)    kf_q[ch_sel] <= ch_din[7:2];
            if (up_pms) begin
                pms_q[ch_sel] <= ch_din[6:4];
                ams_q[ch_sel] <= ch_din[1:0];
            end
        end
    end

    // Slot seen by each later pipeline stage
    assign w_s2 = cycles_q - 5'd1;
    assign w_s3 = cycles_q - 5'd2;
    assign w_s6 = cycles_q - 5'd5;
    assign w_s7 = cycles_q - 5'd6;

    assign rl_I      = rl_q[cycles_q[2:0]];
    assign con_I     = con_q[cycles_q[2:0]];
    assign kc_I      = kc_q[cycles_q[2:0]];
    assign kf_I      = kf_q[cycles_q[2:0]];
    assign pms_I     = pms_q[cycles_q[2:0]];
    assign dt2_I     = dt2_q[cycles_q];
    assign d1l_I     = d1l_q[cycles_q];
    assign fb_II     = fb_q[w_s2[2:0]];
    assign dt1_II    = dt1_q[w_s2];
    assign arate_II  = ar_q[w_s2];
    assign rate1_II  = d1r_q[w_s2];
    assign rate2_II  = d2r_q[w_s2];
    assign rrate_II  = rr_q[w_s2];
    assign ks_III    = ks_q[w_s3];
    assign mul_VI    = mul_q[w_s6];
    assign tl_VII    = tl_q[w_s7];
    assign amsen_VII = amsen_q[w_s7];
    assign ams_VII   = ams_q[w_s7[2:0]];

    assign cycles    = cycles_q;
    assign cur_op    = cycles_q[4:3];
    assign zero      = (cycles_q == 5'd0);
    assign half      = (cycles_q[3:0] == 4'd0);
    assign op31_no   = (cycles_q == 5'd31);
    assign op31_acc  = (cycles_q == 5'd6);
    assign m1_enters = (cycles_q[4:3] == OP_M1);
    assign m2_enters = (cycles_q[4:3] == OP_M2);
    assign c1_enters = (cycles_q[4:3] == OP_C1);
    assign c2_enters = (cycles_q[4:3] == OP_C2);

    assign w_mod          = mod_decode(cycles_q[4:3], con_q[cycles_q[2:0]]);
    assign use_prevprev1  = w_mod.prevprev1;
    assign use_internal_x = w_mod.internal_x;
    assign use_internal_y = w_mod.internal_y;
    assign use_prev2      = w_mod.prev2;
    assign use_prev1      = w_mod.prev1;

    jt51_reg_kon u_kon (
        .clk          (clk),
        .rst          (rst),
        .cen_i        (cen),
        .up_keyon_i   (up_keyon),
        .din_i        (op_din[6:0]),
        .csm_i        (csm),
        .overflow_a_i (overflow_A),
        .cycles_i     (cycles_q),
        .keyon_ii_o   (keyon_II)
    );

endmodule

`default_nettype wire

// File: tb/tb_jt51_reg_file.sv
// ============================================================================
// tb_jt51_reg_file : bench for jt51_reg_file against a slot-level reference
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_jt51_reg_file;

    logic       clk = 1'b0;
    logic       rst, cen;
    logic       up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l;
    logic [1:0] op;
    logic [2:0] ch;
    logic [7:0] op_din;
    logic       up_rl, up_kc, up_kf, up_pms;
    logic [2:0] ch_sel;
    logic [7:0] ch_din;
    logic       up_keyon, csm, overflow_A;
    logic [1:0] rl_I, ams_VII, ks_III, dt2_I, cur_op;
    logic [2:0] fb_II, con_I, pms_I, dt1_II;
    logic [6:0] kc_I, tl_VII;
    logic [5:0] kf_I;
    logic [3:0] mul_VI, d1l_I, rrate_II;
    logic [4:0] arate_II, rate1_II, rate2_II, cycles;
    logic       amsen_VII, keyon_II, op31_no, op31_acc, zero, half;
    logic       m1_enters, m2_enters, c1_enters, c2_enters;
    logic       use_prevprev1, use_internal_x, use_internal_y, use_prev2, use_prev1;

    jt51_reg_file dut (
        .clk(clk), .rst(rst), .cen(cen),
        .up_dt1(up_dt1), .up_tl(up_tl), .up_ks(up_ks), .up_amsen(up_amsen),
        .up_dt2(up_dt2), .up_d1l(up_d1l), .op(op), .ch(ch), .op_din(op_din),
        .up_rl(up_rl), .up_kc(up_kc), .up_kf(up_kf), .up_pms(up_pms),
        .ch_sel(ch_sel), .ch_din(ch_din), .up_keyon(up_keyon), .csm(csm),
        .overflow_A(overflow_A),
        .rl_I(rl_I), .fb_II(fb_II), .con_I(con_I), .kc_I(kc_I), .kf_I(kf_I),
        .pms_I(pms_I), .ams_VII(ams_VII), .dt1_II(dt1_II), .mul_VI(mul_VI),
        .tl_VII(tl_VII), .ks_III(ks_III), .arate_II(arate_II), .amsen_VII(amsen_VII),
        .rate1_II(rate1_II), .dt2_I(dt2_I), .rate2_II(rate2_II), .d1l_I(d1l_I),
        .rrate_II(rrate_II), .keyon_II(keyon_II), .cur_op(cur_op), .op31_no(op31_no),
        .op31_acc(op31_acc), .zero(zero), .half(half), .cycles(cycles),
        .m1_enters(m1_enters), .m2_enters(m2_enters), .c1_enters(c1_enters),
        .c2_enters(c2_enters), .use_prevprev1(use_prevprev1),
        .use_internal_x(use_internal_x), .use_internal_y(use_internal_y),
        .use_prev2(use_prev2), .use_prev1(use_prev1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: per-slot and per-channel field tables plus slot counter
    int m_cyc;
    int m_dt1[32], m_mul[32], m_tl[32], m_ks[32], m_ar[32], m_amsen[32];
    int m_d1r[32], m_dt2[32], m_d2r[32], m_d1l[32], m_rr[32], m_kon[32];
    int m_rl[8], m_fb[8], m_con[8], m_kc[8], m_kf[8], m_pms[8], m_ams[8];
    int m_csm_pend, m_csm_round;
    bit mdl_valid = 1'b0;
    int kon_bit[4] = '{3, 5, 4, 6};
    int mw;

    always @(posedge clk) begin
        if (rst) begin
            m_cyc = 0;
            for (int i = 0; i < 32; i++) begin
                m_dt1[i] = 0; m_mul[i] = 0; m_tl[i] = 0; m_ks[i] = 0; m_ar[i] = 0;
                m_amsen[i] = 0; m_d1r[i] = 0; m_dt2[i] = 0; m_d2r[i] = 0;
                m_d1l[i] = 0; m_rr[i] = 0; m_kon[i] = 0;
            end
            for (int i = 0; i < 8; i++) begin
                m_rl[i] = 0; m_fb[i] = 0; m_con[i] = 0; m_kc[i] = 0;
                m_kf[i] = 0; m_pms[i] = 0; m_ams[i] = 0;
            end
            m_csm_pend  = 0;
            m_csm_round = 0;
            mdl_valid   = 1'b1;
        end else if (cen) begin
            mw = int'(op) * 8 + int'(ch);
            if (up_dt1)   begin m_dt1[mw] = op_din / 16 % 8; m_mul[mw] = op_din % 16; end
            if (up_tl)    m_tl[mw] = op_din % 128;
            if (up_ks)    begin m_ks[mw] = op_din / 64; m_ar[mw] = op_din % 32; end
            if (up_amsen) begin m_amsen[mw] = op_din / 128; m_d1r[mw] = op_din % 32; end
            if (up_dt2)   begin m_dt2[mw] = op_din / 64; m_d2r[mw] = op_din % 32; end
            if (up_d1l)   begin m_d1l[mw] = op_din / 16; m_rr[mw] = op_din % 16; end
            if (up_rl) begin
                m_rl[ch_sel] = ch_din / 64; m_fb[ch_sel] = ch_din / 8 % 8; m_con[ch_sel] = ch_din % 8;
            end
            if (up_kc)  m_kc[ch_sel] = ch_din % 128;
            if (up_kf)  m_kf[ch_sel] = ch_din / 4;
            if (up_pms) begin m_pms[ch_sel] = ch_din / 16 % 8; m_ams[ch_sel] = ch_din % 4; end
            if (up_keyon)
                for (int o = 0; o < 4; o++) m_kon[o * 8 + op_din % 8] = op_din[kon_bit[o]];
            if (m_cyc == 31) begin
                m_csm_round = m_csm_pend;
                m_csm_pend  = 0;
            end
            if (csm && overflow_A) m_csm_pend = 1;
            m_cyc = (m_cyc + 1) % 32;
        end
    end

    // {prevprev1, internal_x, internal_y, prev2, prev1} for operator o under algorithm c
    function automatic logic [4:0] exp_mod(input int o, input int c);
        logic pp1, ix, iy, p2, p1;
        pp1 = 0; ix = 0; p2 = 0; p1 = 0;
        case (o)
            0: pp1 = 1;
            1: begin p2 = (c <= 2); p1 = (c == 1 || c == 5); end
            2: p2 = (c == 0 || c == 3 || c == 4 || c == 5 || c == 6);
            default: begin p2 = (c <= 4); p1 = (c == 3); ix = (c == 2 || c == 5); end
        endcase
        iy = (o != 0) && !(p2 || p1 || ix);
        return {pp1, ix, iy, p2, p1};
    endfunction

    always @(negedge clk) begin
        if (mdl_valid) begin
            int s1, s2, s3, s6, s7;
            logic [4:0] em;
            s1 = m_cyc; s2 = (m_cyc + 31) % 32; s3 = (m_cyc + 30) % 32;
            s6 = (m_cyc + 27) % 32; s7 = (m_cyc + 26) % 32;
            em = exp_mod(s1 / 8, m_con[s1 % 8]);
            chk("cycles",    32'(cycles),    32'(m_cyc));
            chk("zero",      32'(zero),      32'(m_cyc == 0));
            chk("half",      32'(half),      32'(m_cyc % 16 == 0));
            chk("cur_op",    32'(cur_op),    32'(m_cyc / 8));
            chk("op31_no",   32'(op31_no),   32'(m_cyc == 31));
            chk("op31_acc",  32'(op31_acc),  32'(m_cyc == 6));
            chk("m1_enters", 32'(m1_enters), 32'(m_cyc / 8 == 0));
            chk("m2_enters", 32'(m2_enters), 32'(m_cyc / 8 == 1));
            chk("c1_enters", 32'(c1_enters), 32'(m_cyc / 8 == 2));
            chk("c2_enters", 32'(c2_enters), 32'(m_cyc / 8 == 3));
            chk("rl_I",      32'(rl_I),      32'(m_rl[s1 % 8]));
            chk("con_I",     32'(con_I),     32'(m_con[s1 % 8]));
            chk("kc_I",      32'(kc_I),      32'(m_kc[s1 % 8]));
            chk("kf_I",      32'(kf_I),      32'(m_kf[s1 % 8]));
            chk("pms_I",     32'(pms_I),     32'(m_pms[s1 % 8]));
            chk("dt2_I",     32'(dt2_I),     32'(m_dt2[s1]));
            chk("d1l_I",     32'(d1l_I),     32'(m_d1l[s1]));
            chk("fb_II",     32'(fb_II),     32'(m_fb[s2 % 8]));
            chk("dt1_II",    32'(dt1_II),    32'(m_dt1[s2]));
            chk("arate_II",  32'(arate_II),  32'(m_ar[s2]));
            chk("rate1_II",  32'(rate1_II),  32'(m_d1r[s2]));
            chk("rate2_II",  32'(rate2_II),  32'(m_d2r[s2]));
            chk("rrate_II",  32'(rrate_II),  32'(m_rr[s2]));
            chk("keyon_II",  32'(keyon_II),  32'(m_kon[s2] | m_csm_round));
            chk("ks_III",    32'(ks_III),    32'(m_ks[s3]));
            chk("mul_VI",    32'(mul_VI),    32'(m_mul[s6]));
            chk("tl_VII",    32'(tl_VII),    32'(m_tl[s7]));
            chk("amsen_VII", 32'(amsen_VII), 32'(m_amsen[s7]));
            chk("ams_VII",   32'(ams_VII),   32'(m_ams[s7 % 8]));
            chk("mod_sel",   32'({use_prevprev1, use_internal_x, use_internal_y, use_prev2, use_prev1}),
                32'(em));
        end
    end

    task automatic drive_pt();
        @(posedge clk);
        #2;
    endtask

    task automatic tick(input int n);
        repeat (n) drive_pt();
    endtask

    task automatic wait_cyc(input int target);
        int n;
        n = 0;
        while (m_cyc != target && n < 40) begin
            drive_pt();
            n++;
        end
        chk("wait_cyc", 32'(cycles), 32'(target));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; cen = 1;
        {up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l} = '0;
        {up_rl, up_kc, up_kf, up_pms, up_keyon, csm, overflow_A} = '0;
        op = 0; ch = 0; op_din = 0; ch_sel = 0; ch_din = 0;
        tick(3);

        // Reset state literals
        @(negedge clk);
        chk("rst_cycles", 32'(cycles), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_half", 32'(half), 32'd1);
        chk("rst_m1", 32'(m1_enters), 32'd1);
        chk("rst_pp1", 32'(use_prevprev1), 32'd1);
        chk("rst_iy", 32'(use_internal_y), 32'd0);
        chk("rst_keyon", 32'(keyon_II), 32'd0);
        drive_pt();
        rst = 0;

        // Counter walks 0..31 twice
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("lit_cycles", 32'(cycles), 32'(i % 32));
            chk("lit_zero", 32'(zero), 32'((i % 32) == 0));
            chk("lit_half", 32'(half), 32'((i % 16) == 0));
            chk("lit_op31_no", 32'(op31_no), 32'((i % 32) == 31));
            chk("lit_op31_acc", 32'(op31_acc), 32'((i % 32) == 6));
        end

        // TL of C1/ch5 (slot 21)
        drive_pt();
        op = 2; ch = 5; op_din = 8'h7F; up_tl = 1;
        tick(32);
        up_tl = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("lit_tl_VII", 32'(tl_VII), ((m_cyc + 26) % 32 == 21) ? 32'h7F : 32'h0);
        end

        // RL/FB/CON on channel 3
        drive_pt();
        ch_sel = 3; ch_din = 8'hC7; up_rl = 1;
        drive_pt();
        up_rl = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (m_cyc % 8 == 3) begin
                chk("lit_rl_I", 32'(rl_I), 32'd3);
                chk("lit_con_I", 32'(con_I), 32'd7);
                if (m_cyc / 8 != 0) chk("lit_iy", 32'(use_internal_y), 32'd1);
            end
        end

        // Key-on all four operators of channel 2, then clear
        drive_pt();
        op_din = 8'h7A; up_keyon = 1;
        drive_pt();
        up_keyon = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("lit_kon_on", 32'(keyon_II), 32'(((m_cyc + 31) % 32) % 8 == 2));
        end
        drive_pt();
        op_din = 8'h02; up_keyon = 1;
        drive_pt();
        up_keyon = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("lit_kon_off", 32'(keyon_II), 32'd0);
        end

        // Algorithm 5 on channel 0
        drive_pt();
        ch_sel = 0; ch_din = 8'h05; up_rl = 1;
        drive_pt();
        up_rl = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (m_cyc == 8)  chk("lit_prev1_s8", 32'(use_prev1), 32'd1);
            if (m_cyc == 16) chk("lit_prev2_s16", 32'(use_prev2), 32'd1);
            if (m_cyc == 24) chk("lit_ix_s24", 32'(use_internal_x), 32'd1);
        end

        // Remaining fields, some strobes simultaneous
        drive_pt();
        op = 1; ch = 4; op_din = 8'h5A; up_dt1 = 1; up_ks = 1;
        ch_sel = 6; ch_din = 8'h4D; up_kc = 1;
        drive_pt();
        {up_dt1, up_ks, up_kc} = '0;
        op = 3; ch = 7; op_din = 8'hDF; up_ks = 1; up_amsen = 1;
        ch_sel = 6; ch_din = 8'hFC; up_kf = 1;
        drive_pt();
        {up_ks, up_amsen, up_kf} = '0;
        op = 0; ch = 1; op_din = 8'h93; up_amsen = 1; up_d1l = 1;
        ch_sel = 2; ch_din = 8'h53; up_pms = 1;
        drive_pt();
        {up_amsen, up_d1l, up_pms} = '0;
        op = 2; ch = 0; op_din = 8'h8C; up_dt2 = 1;
        drive_pt();
        up_dt2 = 0;
        op = 3; ch = 3; op_din = 8'hA6; up_d1l = 1; up_dt1 = 1;
        drive_pt();
        {up_d1l, up_dt1} = '0;
        tick(40);

        // Clock enable low: no advance, no writes
        begin
            int c0;
            c0 = m_cyc;
            cen = 0; ch_sel = 5; ch_din = 8'h7F; up_kc = 1; up_tl = 1;
            tick(6);
            @(negedge clk);
            chk("lit_cen_hold", 32'(cycles), 32'(c0));
            drive_pt();
            {up_kc, up_tl} = '0;
            cen = 1;
            tick(36);
        end

        // Sweep every algorithm on channel 1
        for (int c = 0; c < 8; c++) begin
            ch_sel = 1; ch_din = 8'(c | (c << 3) | ((c % 4) << 6)); up_rl = 1;
            drive_pt();
            up_rl = 0;
            tick(32);
        end

        // csm without overflow does nothing
        csm = 1; overflow_A = 0;
        drive_pt();
        csm = 0;
        tick(40);

        // CSM round
        wait_cyc(10);
        csm = 1; overflow_A = 1;
        drive_pt();
        csm = 0; overflow_A = 0;
        wait_cyc(0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("lit_csm_on", 32'(keyon_II), 32'd1);
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("lit_csm_off", 32'(keyon_II), 32'd0);
        end

        // Reset dominates active strobes
        drive_pt();
        op = 0; ch = 0; op_din = 8'h55; up_tl = 1; up_keyon = 1; rst = 1;
        tick(2);
        @(negedge clk);
        chk("lit_rst2_cycles", 32'(cycles), 32'd0);
        drive_pt();
        rst = 0; up_tl = 0; up_keyon = 0;
        tick(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
